// File: rtl/lattice_step_sequencer.sv
// lattice_step_sequencer: turns one lattice update step into single-cycle
// enables on clk_in. Each row streams WIDTH shift pulses, one every SCALE
// cycles, and then holds collide_en for WIDTH cycles. After HEIGHT rows it
// issues a one-cycle done pulse.
// Optional build macro: LATTICE_SEQ_FREERUN_EN. When it is defined, DONE
// goes straight back to SHIFT, so steps repeat until reset.
module lattice_step_sequencer #(
   parameter int unsigned WIDTH       = 150,
   parameter int unsigned WIDTH_BITS  = 8,
   parameter int unsigned SCALE       = 4,
   parameter int unsigned LSCALE      = 2,
   parameter int unsigned HEIGHT      = 100,
   parameter int unsigned HEIGHT_BITS = 7
) (
   input  logic                   clk_in,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stall,
   output logic                   shift_en,
   output logic                   collide_en,
   output logic [HEIGHT_BITS-1:0] row_idx,
   output logic [WIDTH_BITS-1:0]  col_idx,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            step_count
);

   localparam int unsigned STEP_BITS = 16;
   localparam logic [LSCALE-1:0]      PHASE_LAST = LSCALE'(SCALE - 1);
   localparam logic [WIDTH_BITS-1:0]  COL_LAST   = WIDTH_BITS'(WIDTH - 1);
   localparam logic [HEIGHT_BITS-1:0] ROW_LAST   = HEIGHT_BITS'(HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_COLLIDE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [LSCALE-1:0]      phase_q, phase_d;
   logic [WIDTH_BITS-1:0]  col_q, col_d;
   logic [HEIGHT_BITS-1:0] row_q, row_d;
   logic [STEP_BITS-1:0]   step_q, step_d;

   // State and counter registers.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         col_q   <= '0;
         row_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         col_q   <= col_d;
         row_q   <= row_d;
         step_q  <= step_d;
      end
   end

   // Next-state and counter sequencing. A stall outside IDLE freezes everything.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      col_d   = col_q;
      row_d   = row_q;
      step_d  = step_q;
      if (!stall || (state_q == ST_IDLE)) begin
         case (state_q)
            ST_IDLE: begin
               phase_d = '0;
               col_d   = '0;
               row_d   = '0;
               if (start) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (phase_q == PHASE_LAST) begin
                  phase_d = '0;
                  if (col_q == COL_LAST) begin
                     col_d   = '0;
                     state_d = ST_COLLIDE;
                  end else begin
                     col_d = col_q + WIDTH_BITS'(1);
                  end
               end else begin
                  phase_d = phase_q + LSCALE'(1);
               end
            end
            ST_COLLIDE: begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     row_d   = '0;
                     state_d = ST_DONE;
                  end else begin
                     row_d   = row_q + HEIGHT_BITS'(1);
                     state_d = ST_SHIFT;
                  end
               end else begin
                  col_d = col_q + WIDTH_BITS'(1);
               end
            end
            ST_DONE: begin
               step_d = step_q + STEP_BITS'(1);
`ifdef LATTICE_SEQ_FREERUN_EN
               state_d = ST_SHIFT;
`else
               state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Moore output decode. A stall masks the strobes but leaves busy high.
   always_comb begin
      shift_en   = 1'b0;
      collide_en = 1'b0;
      done       = 1'b0;
      busy       = (state_q != ST_IDLE);
      row_idx    = row_q;
      col_idx    = col_q;
      step_count = step_q;
      if (!stall) begin
         shift_en   = (state_q == ST_SHIFT) && (phase_q == '0);
         collide_en = (state_q == ST_COLLIDE);
         done       = (state_q == ST_DONE);
      end
   end

endmodule

// File: tb/tb_lattice_step_sequencer.sv
// Testbench for lattice_step_sequencer. It uses WIDTH=4, SCALE=2 and HEIGHT=2.
// The reference model tracks a single position counter inside the step and
// derives the row, column and enables from it arithmetically.
module tb_lattice_step_sequencer;

   localparam int W  = 4;
   localparam int S  = 2;
   localparam int H  = 2;
   localparam int R  = W * (S + 1);   // cycles per row
   localparam int ST = W * S;         // shift cycles per row
   localparam int L  = H * R;         // position of the done cycle

   logic       clk_in = 1'b0;
   logic       reset  = 1'b0;
   logic       start  = 1'b0;
   logic       stall  = 1'b0;
   logic       shift_en, collide_en, busy, done;
   logic [0:0] row_idx;
   logic [1:0] col_idx;
   logic [15:0] step_count;

   lattice_step_sequencer #(
      .WIDTH(4), .WIDTH_BITS(2), .SCALE(2), .LSCALE(1), .HEIGHT(2), .HEIGHT_BITS(1)
   ) dut (
      .clk_in(clk_in), .reset(reset), .start(start), .stall(stall),
      .shift_en(shift_en), .collide_en(collide_en), .row_idx(row_idx),
      .col_idx(col_idx), .busy(busy), .done(done), .step_count(step_count)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_fail   = 0;
   bit m_busy   = 1'b0;
   int m_p      = 0;
   int m_steps  = 0;
   int cyc      = 0;
   int done_q[$];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_p     = 0;
      m_steps = 0;
   endtask

   task automatic model_step(input bit st, input bit sl);
      if (!m_busy) begin
         if (st) begin
            m_busy = 1'b1;
            m_p    = 0;
         end
      end else if (!sl) begin
         if (m_p == L) begin
            m_steps = (m_steps + 1) % 65536;
`ifdef LATTICE_SEQ_FREERUN_EN
            m_p = 0;
`else
            m_busy = 1'b0;
`endif
         end else begin
            m_p++;
         end
      end
   endtask

   task automatic compare_all(input bit sl);
      int e_sh = 0, e_co = 0, e_dn = 0, e_row = 0, e_col = 0, q;
      if (m_busy) begin
         if (m_p == L) begin
            e_dn = sl ? 0 : 1;
         end else begin
            e_row = m_p / R;
            q     = m_p % R;
            if (q < ST) begin
               e_sh  = (!sl && (q % S == 0)) ? 1 : 0;
               e_col = q / S;
            end else begin
               e_co  = sl ? 0 : 1;
               e_col = q - ST;
            end
         end
      end
      check("shift_en",   int'(shift_en),   e_sh);
      check("collide_en", int'(collide_en), e_co);
      check("done",       int'(done),       e_dn);
      check("busy",       int'(busy),       int'(m_busy));
      check("row_idx",    int'(row_idx),    e_row);
      check("col_idx",    int'(col_idx),    e_col);
      check("step_count", int'(step_count), m_steps);
      if (done) done_q.push_back(cyc);
   endtask

   // One clock cycle: drive on the falling edge, check, then follow the rising edge.
   task automatic cycle(input bit st, input bit sl, input bit rs);
      @(negedge clk_in);
      start = st;
      stall = sl;
      reset = rs;
      if (!rs) model_reset();
      #1;
      compare_all(sl);
      @(posedge clk_in);
      if (rs) model_step(st, sl);
      cyc++;
   endtask

   task automatic run(input int n, input int s1, input int s2, input int s3,
                      input int stall_from, input int stall_len);
      for (int i = 0; i < n; i++) begin
         bit st, sl;
         st = (cyc == s1) || (cyc == s2) || (cyc == s3);
         sl = (cyc >= stall_from) && (cyc < stall_from + stall_len);
         cycle(st, sl, 1'b1);
      end
   endtask

   task automatic do_reset();
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      cyc = 0;
      done_q.delete();
   endtask

   initial begin
      // Single step
      do_reset();
      run(52, 0, -1, -1, -1, 0);
      check("single_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 25);
`ifdef LATTICE_SEQ_FREERUN_EN
      check("freerun_done2_cyc", (done_q.size() > 1) ? done_q[1] : -1, 50);
      check("freerun_steps", int'(step_count), 2);
`else
      check("single_done_cnt", done_q.size(), 1);
      check("single_steps", int'(step_count), 1);
`endif

      // Stall mid-SHIFT for 3 cycles
      do_reset();
      run(30, 0, -1, -1, 4, 3);
      check("stall_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 28);
      check("stall_done_cnt", done_q.size(), 1);

      // Start while busy is ignored
      do_reset();
      run(30, 0, 5, 20, -1, 0);
      check("busy_start_done_cnt", done_q.size(), 1);
      check("busy_start_steps", int'(step_count), 1);

      // Reset mid-COLLIDE
      do_reset();
      run(10, 0, -1, -1, -1, 0);
      cycle(1'b0, 1'b0, 1'b0);
      check("rst_busy", int'(busy), 0);
      check("rst_collide", int'(collide_en), 0);
      check("rst_steps", int'(step_count), 0);
      run(20, -1, -1, -1, -1, 0);
      check("rst_done_cnt", done_q.size(), 0);

      // step_count wrap
      do_reset();
      @(negedge clk_in);
      force dut.step_q = 16'hFFFF;
      #1;
      release dut.step_q;
      m_steps = 65535;
      #1;
      check("wrap_preload", int'(step_count), 65535);
      cyc = 0;
      run(27, 0, -1, -1, -1, 0);
      check("wrap_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 25);
      check("wrap_steps", int'(step_count), 0);

      // Random start/stall/reset against the model
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         bit st, sl, rs;
         st = ($urandom_range(0, 7) == 0);
         sl = ($urandom_range(0, 4) == 0);
         rs = ($urandom_range(0, 299) != 0);
         cycle(st, sl, rs);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lattice_step_sequencer.md
# lattice_step_sequencer

Sequences one lattice update step over the row shift-register datapath. It replaces free-running derived clocks with single-cycle enables on `clk_in`. For each of HEIGHT rows it first issues WIDTH shift-enable pulses spaced SCALE cycles apart (streaming phase), then holds a collide enable for WIDTH cycles (compute phase). It sits between the top-level run control and the row shift registers and collision cells.

## Interface
- WIDTH, 150, cells per row
- WIDTH_BITS, 8, width of column index (2^WIDTH_BITS > WIDTH-1)
- SCALE, 4, clk_in cycles per shift pulse (≥2)
- LSCALE, 2, width of phase counter (2^LSCALE ≥ SCALE)
- HEIGHT, 100, rows per step
- HEIGHT_BITS, 7, width of row index (2^HEIGHT_BITS > HEIGHT-1)
- clk_in  input  1  sole clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- start  input  1  request one step; sampled only in IDLE
- stall  input  1  freeze: counters and state hold, enables forced low
- shift_en  output  1  one-cycle shift strobe to row shift registers
- collide_en  output  1  collision-cell enable
- row_idx  output  HEIGHT_BITS  current row, 0..HEIGHT-1
- col_idx  output  WIDTH_BITS  current column, 0..WIDTH-1
- busy  output  1  high in SHIFT, COLLIDE, DONE
- done  output  1  one-cycle pulse at end of step
- step_count  output  16  completed steps, wraps 65535→0

## Operation
- States: IDLE, SHIFT, COLLIDE, DONE. Counters: phase (LSCALE), col (WIDTH_BITS), row (HEIGHT_BITS), step (16).
- IDLE: all counters except step at 0. If start=1, go to SHIFT. Otherwise stay.
- SHIFT: phase counts 0..SCALE-1 and wraps. col increments on each phase wrap. shift_en = (phase==0).
  - At phase==SCALE-1 and col==WIDTH-1: go to COLLIDE, with col and phase cleared.
- COLLIDE: collide_en=1, col counts 0..WIDTH-1.
  - At col==WIDTH-1 with row<HEIGHT-1: row+1, col=0, go to SHIFT.
  - At col==WIDTH-1 with row==HEIGHT-1: row=0, go to DONE.
- DONE: done=1, step_count+1 (modulo 2^16), then go to IDLE (see Configuration).
- stall=1 in any non-IDLE state:
  - No state or counter changes.
  - shift_en, collide_en and done forced 0.
  - busy stays 1.
  - A step resumes exactly where it froze.
- stall in IDLE has no effect. A start that arrives while busy is ignored, not queued.
- Outputs are Moore decodes of registered state and counters. row_idx and col_idx are the counter values.
- Reset values: state IDLE, all counters 0, all outputs 0.
- Reset asserted mid-step aborts the step with no done pulse, and step_count returns to 0.

## Timing
- start high at edge N (in IDLE): SHIFT from cycle N+1, with the first shift_en in cycle N+1.
- Row cost: WIDTH·SCALE SHIFT cycles + WIDTH COLLIDE cycles.
- Step length (no stall): HEIGHT·WIDTH·(SCALE+1) cycles + 1 DONE cycle.
- The done cycle is the first cycle after the last collide cycle. busy falls the cycle after done.
- Each stall cycle extends latency by exactly one cycle.
- start sampled in the same cycle that IDLE is re-entered is honoured. start high during DONE is not.

## Configuration
- LATTICE_SEQ_FREERUN_EN defined:
  - DONE goes directly to SHIFT, with no IDLE cycle and no start required.
  - The first step still requires start.
  - Only reset stops the loop.
- Not defined: DONE always returns to IDLE and waits for start.

## Test plan
All scenarios use WIDTH=4, SCALE=2, HEIGHT=2.
- Single step: one start pulse, no stall.
  - shift_en pulses on cycles 1,3,5,7 and 13,15,17,19.
  - collide_en on 9–12 and 21–24.
  - done on cycle 25, step_count=1.
- Stall mid-SHIFT: stall high for 3 cycles starting at cycle 4.
  - Enables low during the stall, counters frozen.
  - done moves to cycle 28.
- Start while busy: start pulses at cycles 5 and 20.
  - Ignored; exactly one done, step_count=1.
- Reset mid-COLLIDE: reset low at cycle 10.
  - All outputs 0 immediately, state IDLE, no done, step_count=0.
- Wrap: preload via 65535 steps (or force), then run one more step.
  - step_count reads 0 after that step's done.
- LATTICE_SEQ_FREERUN_EN: single start.
  - done on cycles 25 and 50.
  - shift_en on cycle 26 with no IDLE gap.
  - busy never falls.
